// File: rtl/rip_arb_pkg.sv
// Shared helpers for the round-robin FIFO arbiter slice.
// Width-dependent types (src_t, fifo_entry_t) are declared inside the modules that own the widths.
package rip_arb_pkg;

    // Round-robin successor of a requester index, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

    // Width of one stored FIFO entry: source tag followed by payload.
    function automatic int entry_width(input int src_w, input int data_w);
        return src_w + data_w;
    endfunction

endpackage

// File: rtl/rip_fifo_sync.sv
// Synchronous FIFO with a show-ahead head word and synchronous reset.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module rip_fifo_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  wr_fire;
    logic                  rd_fire;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                     (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_fire);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which words are valid.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/rip_rr_arbiter.sv
// Round-robin priority pick over a request vector, searching upward from rr_ptr.
// rr_ptr moves one past the granted index whenever the grant is used.
module rip_rr_arbiter
    import rip_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   grant_idx
);

    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(rr_ptr_q) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = SRC_W'(idx);
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance) begin
            rr_ptr_d = SRC_W'(rr_next(int'(grant_idx), NUM_REQ));
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/rip_fifo_arbiter.sv
// Round-robin write arbiter feeding one shared FIFO, with a registered valid/ready
// output stage that tags each word with its source and tracks total occupancy.
module rip_fifo_arbiter
    import rip_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int SRC_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_mask,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]              out_src,
    input  logic                          out_ready,
    output logic [ADDR_WIDTH:0]           level
);

    typedef logic [SRC_W-1:0] src_t;

    typedef struct packed {
        src_t                  src;
        logic [DATA_WIDTH-1:0] data;
    } fifo_entry_t;

    localparam int ENTRY_W = entry_width(SRC_W, DATA_WIDTH);
    localparam int LVL_W   = ADDR_WIDTH + 1;

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    src_t                  grant_idx;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  wr_en;
    logic                  rd_en;
    logic                  out_xfer;
    fifo_entry_t           wr_entry;
    logic [ENTRY_W-1:0]    rd_bits;
    fifo_entry_t           rd_entry;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    src_t                  out_src_q,   out_src_d;
    logic [LVL_W-1:0]      level_q,     level_d;

    assign eligible = req_valid & req_mask;

    // Reset and a full FIFO both suppress the grant in the same cycle.
    assign req_ready = (rst || fifo_full) ? '0 : grant;
    assign wr_en     = |req_ready;
    assign out_xfer  = out_valid_q && out_ready;
    assign rd_en     = !fifo_empty && (!out_valid_q || out_ready);
    assign rd_entry  = fifo_entry_t'(rd_bits);

    rip_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (eligible),
        .advance   (wr_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        wr_entry.src  = grant_idx;
        wr_entry.data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                wr_entry.data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    rip_fifo_sync #(
        .DATA_WIDTH (ENTRY_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_data (rd_bits),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Output register refills from the FIFO head whenever it is empty or being drained.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (rd_en) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_entry.data;
            out_src_d   = rd_entry.src;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        level_d = level_q;
        case ({wr_en, out_xfer})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            level_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            level_q     <= level_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign level     = level_q;

endmodule
